// File: rtl/conv_act_sequencer.sv
// Activation sequencer for one binarised conv layer: handshakes input pixels, sweeps the
// output-channel fold per pixel, gates maxpool strobes on window validity and flushes at frame end.
module conv_act_sequencer #(
    parameter int ch_in  = 64,
    parameter int w_in   = 32,
    parameter int pad    = 1,
    parameter int fold   = 1,
    parameter int fold_w = fold > 1 ? $clog2(fold) : 1,
    parameter int n_pix  = w_in * w_in,
    parameter int D      = pad * w_in + pad
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ch_in-1:0]  in_act,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ch_in-1:0]  stream_act,
    output logic              stream_act_en,
    output logic [fold_w-1:0] fold_add,
    output logic              stream_maxpool_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned cnt_w = $clog2(n_pix + D + 1);
    localparam logic [cnt_w-1:0]  n_pix_c   = cnt_w'(n_pix);
    localparam logic [cnt_w-1:0]  lag_c     = cnt_w'(D);
    localparam logic [fold_w-1:0] fold_last = fold_w'(fold - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SWEEP,
        COMMIT,
        FLUSH_LOAD
    } state_t;

    state_t             state, state_nxt;
    logic [cnt_w-1:0]   pix_cnt, pix_cnt_nxt;
    logic [cnt_w-1:0]   out_cnt, out_cnt_nxt;
    logic [fold_w-1:0]  fold_cnt, fold_cnt_nxt;
    logic [ch_in-1:0]   stream_act_nxt;
    logic               stream_act_en_nxt;
    logic [fold_w-1:0]  fold_add_nxt;
    logic               maxpool_nxt;
    logic               done_nxt;
    logic               busy_nxt;
    logic               in_ready_nxt;

    // Next-state and next-output logic; every output is the registered image of these values.
    always_comb begin
        state_nxt      = state;
        pix_cnt_nxt    = pix_cnt;
        out_cnt_nxt    = out_cnt;
        fold_cnt_nxt   = fold_cnt;
        stream_act_nxt = stream_act;
        maxpool_nxt    = 1'b0;
        done_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    stream_act_nxt = in_act;
                    state_nxt      = LOAD;
                end
            end
            LOAD, FLUSH_LOAD: begin
                pix_cnt_nxt  = pix_cnt + cnt_w'(1);
                fold_cnt_nxt = '0;
                state_nxt    = SWEEP;
            end
            SWEEP: begin
                if (fold_cnt == fold_last) begin
                    state_nxt = COMMIT;
                    // Window is valid once the loaded pixel index reaches the centre lag.
                    if (pix_cnt > lag_c) begin
                        out_cnt_nxt = out_cnt + cnt_w'(1);
                        maxpool_nxt = 1'b1;
                        done_nxt    = (out_cnt + cnt_w'(1)) == n_pix_c;
                    end
                end else begin
                    fold_cnt_nxt = fold_cnt + fold_w'(1);
                end
            end
            COMMIT: begin
                if (frame_done) begin
                    pix_cnt_nxt = '0;
                    out_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else if (pix_cnt >= n_pix_c) begin
                    stream_act_nxt = '0;
                    state_nxt      = FLUSH_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        stream_act_en_nxt = (state_nxt == LOAD) || (state_nxt == FLUSH_LOAD);
        fold_add_nxt      = (state_nxt == SWEEP) ? fold_cnt_nxt : '0;
        busy_nxt          = state_nxt != IDLE;
        in_ready_nxt      = state_nxt == IDLE;
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            out_cnt  <= '0;
            fold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pix_cnt  <= pix_cnt_nxt;
            out_cnt  <= out_cnt_nxt;
            fold_cnt <= fold_cnt_nxt;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stream_act        <= '0;
            stream_act_en     <= 1'b0;
            fold_add          <= '0;
            stream_maxpool_en <= 1'b0;
            frame_done        <= 1'b0;
            busy              <= 1'b0;
            in_ready          <= 1'b0;
        end else begin
            stream_act        <= stream_act_nxt;
            stream_act_en     <= stream_act_en_nxt;
            fold_add          <= fold_add_nxt;
            stream_maxpool_en <= maxpool_nxt;
            frame_done        <= done_nxt;
            busy              <= busy_nxt;
            in_ready          <= in_ready_nxt;
        end
    end

endmodule
